// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input sync, mid-bit sampling, byte out with done/frame-error pulses.
// Ports: clk, rst_n, din (serial in), dout[7:0], rx_done, frame_err, busy.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din,
  output logic [7:0] dout,
  output logic       rx_done,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int H  = CLKS_PER_BIT / 2;

  localparam logic [CW-1:0] HLAST = CW'(H - 1);
  localparam logic [CW-1:0] BLAST = CW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic          sync1;
  logic          s;
  logic          s_d;
  logic          fall;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    sh;

  // sync flops reset high so the line reads idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      s     <= 1'b1;
      s_d   <= 1'b1;
    end else begin
      sync1 <= din;
      s     <= sync1;
      s_d   <= s;
    end
  end

  assign fall = s_d & ~s;
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      sh        <= '0;
      dout      <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (fall) begin
            cnt   <= '0;
            state <= START;
          end
        end
        START: begin
          if (cnt == HLAST) begin
            cnt   <= '0;
            idx   <= '0;
            state <= s ? IDLE : DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == BLAST) begin
            cnt <= '0;
            sh  <= {s, sh[7:1]};
            if (idx == 3'd7) begin
              state <= STOP;
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (cnt == BLAST) begin
            cnt   <= '0;
            state <= IDLE;
            if (s) begin
              dout    <= sh;
              rx_done <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
